// File: rtl/cpu_oci_trace_pkg.sv
// rtl/cpu_oci_trace_pkg.sv - shared trace atom/word widths and packing helper
package cpu_oci_trace_pkg;

    localparam int ATOM_W         = 3;
    localparam int ATOMS_PER_WORD = 10;
    localparam int TRACE_WORD_W   = ATOM_W * ATOMS_PER_WORD;
    localparam int CNT_W          = 4;

    typedef logic [ATOM_W-1:0]       trace_atom_t;
    typedef logic [TRACE_WORD_W-1:0] trace_word_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ATOMS_PER_WORD);

    // Slot ATOMS_PER_WORD shifts the atom out entirely, yielding zero.
    function automatic trace_word_t place_atom(input trace_atom_t atom, input logic [CNT_W-1:0] slot);
        return trace_word_t'(atom) << (ATOM_W * int'(slot));
    endfunction

endpackage

// File: rtl/cpu_oci_dct_outreg.sv
// rtl/cpu_oci_dct_outreg.sv - single-entry valid/ready register for packed trace words
module cpu_oci_dct_outreg
    import cpu_oci_trace_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  trace_word_t      data_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             ready_i,
    output logic             valid_o,
    output trace_word_t      data_o,
    output logic [CNT_W-1:0] count_o
);

    logic             valid_q;
    trace_word_t      data_q;
    logic [CNT_W-1:0] count_q;

    // The caller only asserts load_i when the slot is empty or draining this edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            count_q <= count_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign count_o = count_q;

endmodule

// File: rtl/cpu_oci_dct_packer.sv
// rtl/cpu_oci_dct_packer.sv - packs 3-bit trace atoms into 30-bit words with flush and end-of-trace drain
module cpu_oci_dct_packer
    import cpu_oci_trace_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        atom_valid,
    input  logic [2:0]  atom_data,
    output logic        atom_ready,
    input  logic        flush,
    input  logic        trace_stop,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        tw_valid,
    output logic [29:0] tw_data,
    output logic [3:0]  tw_count,
    input  logic        tw_ready,
    output logic        test_ending,
    output logic        test_has_ended
);

    trace_word_t      buf_q, buf_d, buf_app, load_data;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_app, load_cnt, acc_inc;
    logic             pend_q, pend_d;
    logic             ending_q, ended_q;
    logic             load_ok, full_q, accept, flush_evt, emit;

    assign load_ok    = !tw_valid || tw_ready;
    assign full_q     = (cnt_q == FULL_CNT);
    assign atom_ready = reset_n && !ending_q && (!full_q || load_ok);
    assign accept     = atom_valid && atom_ready;
    assign flush_evt  = flush || trace_stop || pend_q;
    assign acc_inc    = {{(CNT_W-1){1'b0}}, accept};

    always_comb begin
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        emit      = 1'b0;
        load_data = buf_q;
        load_cnt  = cnt_q;
        buf_app   = accept ? (buf_q | place_atom(atom_data, cnt_q)) : buf_q;
        cnt_app   = cnt_q + acc_inc;
        if (full_q) begin
            // A held full word leaves first; a same-cycle atom starts the next word.
            if (load_ok) begin
                emit   = 1'b1;
                buf_d  = accept ? place_atom(atom_data, '0) : '0;
                cnt_d  = acc_inc;
                pend_d = flush_evt && accept;
            end else begin
                pend_d = flush_evt;
            end
        end else if (cnt_app == FULL_CNT || (flush_evt && cnt_app != '0)) begin
            if (load_ok) begin
                emit      = 1'b1;
                load_data = buf_app;
                load_cnt  = cnt_app;
                buf_d     = '0;
                cnt_d     = '0;
                pend_d    = 1'b0;
            end else begin
                buf_d  = buf_app;
                cnt_d  = cnt_app;
                pend_d = flush_evt;
            end
        end else begin
            buf_d  = buf_app;
            cnt_d  = cnt_app;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            ending_q <= 1'b0;
            ended_q  <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            ending_q <= ending_q || trace_stop;
            ended_q  <= ended_q || (ending_q && cnt_q == '0 && !pend_q && !tw_valid);
        end
    end

    cnt_le_full: assert property (@(posedge clk) disable iff (!reset_n) cnt_q <= FULL_CNT);

    cpu_oci_dct_outreg u_outreg (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (emit),
        .data_i  (load_data),
        .count_i (load_cnt),
        .ready_i (tw_ready),
        .valid_o (tw_valid),
        .data_o  (tw_data),
        .count_o (tw_count)
    );

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign test_ending    = ending_q;
    assign test_has_ended = ended_q;

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// tb/tb_cpu_oci_dct_packer.sv - directed and randomized self-checking bench for cpu_oci_dct_packer
module tb_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n, atom_valid, atom_ready, flush, trace_stop;
    logic [2:0]  atom_data;
    logic [29:0] dct_buffer, tw_data;
    logic [3:0]  dct_count, tw_count;
    logic        tw_valid, tw_ready, test_ending, test_has_ended;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0]  acc_q[$];
    logic [29:0] got_data[$];
    logic [3:0]  got_cnt[$];

    always #5 clk = ~clk;

    cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .atom_valid     (atom_valid),
        .atom_data      (atom_data),
        .atom_ready     (atom_ready),
        .flush          (flush),
        .trace_stop     (trace_stop),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .tw_valid       (tw_valid),
        .tw_data        (tw_data),
        .tw_count       (tw_count),
        .tw_ready       (tw_ready),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        #1;
        if (atom_valid && atom_ready) acc_q.push_back(atom_data);
        if (tw_valid && tw_ready) begin
            got_data.push_back(tw_data);
            got_cnt.push_back(tw_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_atom(input logic [2:0] a);
        bit done;
        done       = 1'b0;
        atom_valid = 1'b1;
        atom_data  = a;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            done = atom_ready;
            tick();
        end
        atom_valid = 1'b0;
        chk("send_atom_timeout", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; atom_valid = 1'b0; atom_data = '0;
        flush = 1'b0; trace_stop = 1'b0; tw_ready = 1'b0;
        #1;
        chk("reset_atom_ready", 32'(atom_ready), 32'd0);
        tick();
        tick();
        acc_q.delete(); got_data.delete(); got_cnt.delete();
        reset_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_buffer"}, 32'(dct_buffer), 32'd0);
        chk({tag, "_count"}, 32'(dct_count), 32'd0);
        chk({tag, "_tw_valid"}, 32'(tw_valid), 32'd0);
        chk({tag, "_tw_data"}, 32'(tw_data), 32'd0);
        chk({tag, "_tw_count"}, 32'(tw_count), 32'd0);
        chk({tag, "_ending"}, 32'(test_ending), 32'd0);
        chk({tag, "_ended"}, 32'(test_has_ended), 32'd0);
    endtask

    // Every delivered word must carry the next accepted atoms, in order, nothing left over.
    task automatic check_stream(input string tag);
        logic [29:0] d, exp;
        logic [3:0]  c;
        while (got_cnt.size() > 0) begin
            c = got_cnt.pop_front();
            d = got_data.pop_front();
            exp = '0;
            chk({tag, "_word_count_range"}, 32'(c >= 4'd1 && c <= 4'd10), 32'd1);
            for (int i = 0; i < int'(c); i++)
                if (acc_q.size() > 0) exp = exp | (30'(acc_q.pop_front()) << (3 * i));
            chk({tag, "_word_data"}, 32'(d), 32'(exp));
        end
        chk({tag, "_undelivered"}, 32'(acc_q.size()), 32'd0);
    endtask

    initial begin
        logic [2:0]  bp[20];
        logic [29:0] w1, w2;
        bit          ended;

        // Reset state
        do_reset();
        check_all_zero("reset");

        // Fill one word back-to-back
        tw_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_atom(3'((i + 1) % 8));
        chk("fill_tw_valid", 32'(tw_valid), 32'd1);
        chk("fill_tw_count", 32'(tw_count), 32'd10);
        chk("fill_tw_data", 32'(tw_data), 32'(30'o2107654321));
        chk("fill_dct_count", 32'(dct_count), 32'd0);
        tick();
        chk("fill_single_pulse", 32'(tw_valid), 32'd0);
        check_stream("fill");

        // Partial flush, then flush of an empty buffer
        send_atom(3'd5); send_atom(3'd6); send_atom(3'd7);
        chk("partial_buffer", 32'(dct_buffer), 32'(30'o765));
        flush = 1'b1; tick(); flush = 1'b0;
        chk("partial_tw_valid", 32'(tw_valid), 32'd1);
        chk("partial_tw_count", 32'(tw_count), 32'd3);
        chk("partial_tw_data", 32'(tw_data), 32'(30'o765));
        chk("partial_dct_count", 32'(dct_count), 32'd0);
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        chk("empty_flush_no_word", 32'(tw_valid), 32'd0);
        tick();
        chk("empty_flush_still_none", 32'(tw_valid), 32'd0);
        check_stream("partial");

        // Backpressure: 20 atoms with the output blocked
        tw_ready = 1'b0;
        w1 = '0; w2 = '0;
        for (int i = 0; i < 20; i++) begin
            bp[i] = 3'($urandom_range(0, 7));
            if (i < 10) w1 = w1 | (30'(bp[i]) << (3 * i));
            else        w2 = w2 | (30'(bp[i]) << (3 * (i - 10)));
        end
        for (int i = 0; i < 20; i++) send_atom(bp[i]);
        atom_valid = 1'b1; #1;
        chk("bp_atom_ready_low", 32'(atom_ready), 32'd0);
        chk("bp_dct_count_full", 32'(dct_count), 32'd10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_word1_stable", 32'(tw_data), 32'(w1));
            chk("bp_valid_held", 32'(tw_valid), 32'd1);
        end
        atom_valid = 1'b0;
        tw_ready = 1'b1;
        tick();
        chk("bp_word2_data", 32'(tw_data), 32'(w2));
        chk("bp_word2_valid", 32'(tw_valid), 32'd1);
        chk("bp_drained_count", 32'(dct_count), 32'd0);
        tick();
        chk("bp_idle", 32'(tw_valid), 32'd0);
        check_stream("bp");

        // Atom and flush together at 9 atoms
        for (int i = 0; i < 9; i++) send_atom(3'($urandom_range(0, 7)));
        atom_valid = 1'b1; atom_data = 3'd4; flush = 1'b1;
        tick();
        atom_valid = 1'b0; flush = 1'b0;
        chk("af_tw_count", 32'(tw_count), 32'd10);
        chk("af_dct_count", 32'(dct_count), 32'd0);
        tick();
        chk("af_single_word", 32'(tw_valid), 32'd0);
        check_stream("af");

        // End of trace with the output blocked for 5 cycles
        tw_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_atom(3'($urandom_range(0, 7)));
        trace_stop = 1'b1; tick(); trace_stop = 1'b0;
        chk("eot_ending", 32'(test_ending), 32'd1);
        chk("eot_tw_count", 32'(tw_count), 32'd4);
        atom_valid = 1'b1; atom_data = 3'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("eot_atom_ready_low", 32'(atom_ready), 32'd0);
            chk("eot_not_ended", 32'(test_has_ended), 32'd0);
            tick();
        end
        atom_valid = 1'b0;
        tw_ready = 1'b1;
        tick();
        chk("eot_handshake_done", 32'(tw_valid), 32'd0);
        chk("eot_not_yet_ended", 32'(test_has_ended), 32'd0);
        tick();
        chk("eot_ended", 32'(test_has_ended), 32'd1);
        tick();
        chk("eot_ended_sticky", 32'(test_has_ended), 32'd1);
        check_stream("eot");

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 16; i++) send_atom(3'($urandom_range(0, 7)));
        chk("mid_pre_count", 32'(dct_count), 32'd6);
        chk("mid_pre_valid", 32'(tw_valid), 32'd1);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check_all_zero("midreset");
        acc_q.delete(); got_data.delete(); got_cnt.delete();
        tw_ready = 1'b1;
        send_atom(3'd3);
        chk("mid_first_atom_slot", 32'(dct_buffer), 32'd3);
        chk("mid_first_atom_count", 32'(dct_count), 32'd1);

        // Randomized traffic against the accept rule and the delivery scoreboard
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            atom_valid = ($urandom_range(0, 3) != 0);
            atom_data  = 3'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 7) == 0);
            tw_ready   = ($urandom_range(0, 2) != 0);
            #1;
            chk("rnd_accept_rule", 32'(atom_ready),
                32'(!test_ending && (dct_count < 4'd10 || !tw_valid || tw_ready)));
            chk("rnd_count_le_10", 32'(dct_count <= 4'd10), 32'd1);
            tick();
        end
        atom_valid = 1'b0; flush = 1'b0; tw_ready = 1'b1;
        trace_stop = 1'b1; tick(); trace_stop = 1'b0;
        ended = 1'b0;
        for (int i = 0; i < 40 && !ended; i++) begin
            ended = test_has_ended;
            if (!ended) tick();
        end
        chk("rnd_drain_ended", 32'(ended), 32'd1);
        check_stream("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_oci_dct_packer.md
Name: cpu_oci_dct_packer

Overview:
- Packs 3-bit debug-trace atoms from the OCI trace compressor into 30-bit trace words of up to 10 atoms.
- Exposes the live packing buffer and fill count (dct_buffer, dct_count) to the OCI test bench and debug monitor.
- Hands completed or flushed words to the downstream trace FIFO through a valid/ready handshake with a one-entry output register.
- Sits directly upstream of the OCI test bench and the trace FIFO write port.

Parameters:
- ATOM_W, 3, width of one trace atom
- ATOMS_PER_WORD, 10, atoms per packed word (ATOM_W*ATOMS_PER_WORD = 30)
- CNT_W, 4, width of the fill counter

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- atom_valid  in  1  atom_data is valid this cycle
- atom_data  in  3  trace atom
- atom_ready  out  1  packer accepts an atom this cycle
- flush  in  1  single-cycle request to emit the partial buffer
- trace_stop  in  1  end of trace: flush, then signal completion
- dct_buffer  out  30  live packing buffer
- dct_count  out  4  atoms currently in buffer, 0..10
- tw_valid  out  1  output word valid
- tw_data  out  30  packed word
- tw_count  out  4  atoms in tw_data, 1..10
- tw_ready  in  1  downstream accepts the word
- test_ending  out  1  trace_stop seen, drain in progress
- test_has_ended  out  1  all atoms delivered downstream; sticky

Behaviour:
- Reset (reset_n low at a clk edge): every output is zero. This clears dct_buffer, dct_count, tw_valid, tw_data, tw_count, test_ending and test_has_ended. Reset asserted mid-word discards the partial buffer and any pending output word.
- Packing order: the atom accepted while dct_count = k is written to dct_buffer[3k+2:3k]. Bits above 3*dct_count read zero.
- Accept rule: atom_ready = !test_ending && (dct_count < 10 || !tw_valid || tw_ready).
  - An atom transfers when atom_valid && atom_ready.
- Word emission moves the buffer into the output register. Emission happens on either:
  - an accepted atom raising the count to 10, or
  - a flush or trace_stop event while dct_count > 0.
- The output register loads in the same edge as the accept. tw_valid is asserted the next cycle, giving 1-cycle latency from the 10th atom to tw_valid.
- Output register load is allowed only when !tw_valid || tw_ready, so it behaves as a skid-free single-entry register.
- If an emission is due but the register is blocked, the buffer holds at 10 atoms (atom_ready low) or the flush stays pending. The pending flush is held in an internal flag until the emission succeeds.
- On emission, dct_buffer and dct_count go to 0.
  - If an atom is accepted in the same cycle as a flush emission, the atom is appended first. When that makes 10, one full word is emitted.
  - Otherwise the atom joins the flushed word; the packer never splits an atom across words.
- Flush with dct_count = 0 and no same-cycle atom emits nothing and is dropped.
- tw_data, tw_count and tw_valid hold stable while tw_valid && !tw_ready. tw_valid clears on handshake unless a new word loads in the same edge.
- trace_stop:
  - sets test_ending, which stays set until reset, and is treated as a flush.
  - Atoms presented in the same cycle are still accepted; atom_ready drops from the next cycle.
- test_has_ended rises one cycle after test_ending && dct_count == 0 && !pending_flush && !tw_valid. It is sticky until reset.
- dct_count never exceeds 10; values 11..15 are unreachable and flagged by a simulation assertion.

Decomposition:
- Shared package cpu_oci_trace_pkg holds:
  - constants ATOM_W, ATOMS_PER_WORD, TRACE_WORD_W = 30, CNT_W
  - typedef trace_atom_t (3 bits)
  - typedef trace_word_t (30 bits)
- One natural sub-module: cpu_oci_dct_outreg, the single-entry valid/ready output register carrying tw_data and tw_count.
- Packing buffer, counter and end-of-trace control stay in the top.

Test Plan:
- Fill word: 10 atoms 1..7,0,1,2 back-to-back with tw_ready = 1.
  - Expect one tw_valid pulse, tw_count = 10, tw_data = 30'o2107654321, dct_count back to 0.
- Partial flush: 3 atoms 5,6,7 then flush.
  - Expect tw_count = 3, tw_data = 30'o765, and no word on a second flush with an empty buffer.
- Backpressure: tw_ready = 0, send 20 atoms.
  - First word held stable; atom_ready drops at dct_count = 10.
  - Raising tw_ready drains word 1, word 2 follows next cycle, and no atom is lost or duplicated.
- Simultaneous atom and flush at dct_count = 9.
  - Single word with tw_count = 10; next cycle dct_count = 0.
- End of trace: 4 atoms, trace_stop with tw_ready = 0 for 5 cycles, then tw_ready = 1.
  - test_ending is set immediately and atom_ready stays low.
  - test_has_ended rises 1 cycle after the handshake.
- Reset mid-operation: reset_n low for one cycle with dct_count = 6 and tw_valid = 1.
  - All outputs 0 next cycle; the following atom lands in bits [2:0].
